// File: rtl/dmem_bus_responder.sv
// rtl/dmem_bus_responder.sv - data-side load/store responder: word RAM plus LED/switch MMIO window
module dmem_bus_responder #(
    parameter int          DEPTH_LOG2 = 14,
    parameter logic [31:0] LED_ADDR   = 32'hFFFF_FC60,
    parameter logic [31:0] SW_ADDR    = 32'hFFFF_FC70
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] led_out,
    input  logic [15:0] sw_in
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam int         WORDS  = 1 << DEPTH_LOG2;

    logic [1:0]            state;
    logic [31:0]           ram [0:WORDS-1];
    logic [31:0]           rd_word;
    logic [1:0]            rd_lane;
    logic [2:0]            rd_funct3;
    logic [15:0]           sw_meta;
    logic [15:0]           sw_sync;

    logic                  accept;
    logic                  in_ram;
    logic                  is_led;
    logic                  is_sw;
    logic                  is_mmio;
    logic                  f3_legal;
    logic                  misaligned;
    logic                  req_err;
    logic                  ram_we;
    logic [3:0]            byte_en;
    logic [31:0]           wdata_rep;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic [7:0]            lane_byte;
    logic [15:0]           lane_half;
    logic [31:0]           load_data;

    assign req_ready = rst && (state == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign in_ram    = (req_addr >> (DEPTH_LOG2 + 2)) == 32'd0;
    assign is_led    = req_addr[31:2] == LED_ADDR[31:2];
    assign is_sw     = req_addr[31:2] == SW_ADDR[31:2];
    assign is_mmio   = is_led || is_sw;
    assign req_idx   = req_addr[DEPTH_LOG2+1:2];

    always_comb begin
        f3_legal   = 1'b0;
        misaligned = 1'b0;
        case (req_funct3)
            3'b000: f3_legal = 1'b1;
            3'b001: begin
                f3_legal   = 1'b1;
                misaligned = req_addr[0];
            end
            3'b010: begin
                f3_legal   = 1'b1;
                misaligned = |req_addr[1:0];
            end
            3'b100, 3'b101: begin
                f3_legal   = !req_we;
                misaligned = req_funct3[0] && req_addr[0];
            end
            default: f3_legal = 1'b0;
        endcase
    end

    // MMIO registers are word-only; anything narrower there is rejected.
    assign req_err = !f3_legal || misaligned || (!in_ram && !is_mmio)
                   || (is_mmio && req_funct3 != 3'b010);
    assign ram_we  = accept && req_we && !req_err && in_ram;

    always_comb begin
        byte_en   = 4'b1111;
        wdata_rep = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                byte_en   = 4'b0001 << req_addr[1:0];
                wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                byte_en   = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            default: byte_en = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    ram[req_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
                end
            end
        end
        if (accept) begin
            rd_word   <= ram[req_idx];
            rd_lane   <= req_addr[1:0];
            rd_funct3 <= req_funct3;
        end
    end

    always_comb begin
        lane_byte = rd_word[{rd_lane, 3'b000} +: 8];
        lane_half = rd_lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (rd_funct3)
            3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
            3'b100:  load_data = {24'd0, lane_byte};
            3'b101:  load_data = {16'd0, lane_half};
            default: load_data = rd_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sw_meta <= 16'd0;
            sw_sync <= 16'd0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            led_out   <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (req_err) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'd0;
                        end else if (in_ram && !req_we) begin
                            state <= S_RD;
                        end else begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= 32'd0;
                            if (is_mmio && !req_we) begin
                                rsp_rdata <= is_led ? {16'd0, led_out} : {16'd0, sw_sync};
                            end
                            if (is_led && req_we) begin
                                led_out <= req_wdata[15:0];
                            end
                        end
                    end
                end
                S_RD: begin
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= load_data;
                end
                default: begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bus_responder.sv
// tb/tb_dmem_bus_responder.sv - directed bench with a byte-level memory model and per-cycle output compare
module tb_dmem_bus_responder;

    localparam logic [31:0] LED_A     = 32'hFFFF_FC60;
    localparam logic [31:0] SW_A      = 32'hFFFF_FC70;
    localparam int unsigned RAM_BYTES = 4 * (1 << 14);

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [2:0]  req_funct3 = 3'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] led_out;
    logic [15:0] sw_in = 16'd0;

    dmem_bus_responder dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .led_out(led_out), .sw_in(sw_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] d;
        bit          e;
        bit          hl;
        logic [31:0] ld;
        bit          le;
    } exp_t;

    exp_t        q[$];
    bit [7:0]    mem_m[int unsigned];
    logic [15:0] led_m = 16'd0;
    int          cyc = 0;
    int          last_due = -1;
    int          total = 0;
    int          bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    // Expected response of one request, from the access rules alone; applies store side effects.
    function automatic void model(input bit we, input logic [31:0] a, input logic [31:0] wd,
                                  input logic [2:0] f3, output logic [31:0] d, output bit e,
                                  output int lat);
        int size = 0;
        bit sgn  = 0;
        d = 32'd0; e = 0; lat = 1;
        if (we) begin
            if (f3 == 3'd0) size = 1; else if (f3 == 3'd1) size = 2; else if (f3 == 3'd2) size = 4;
        end else begin
            case (f3)
                3'd0: begin size = 1; sgn = 1; end
                3'd1: begin size = 2; sgn = 1; end
                3'd2: size = 4;
                3'd4: size = 1;
                3'd5: size = 2;
                default: size = 0;
            endcase
        end
        if (size == 0 || (a % size) != 0) e = 1;
        else if (a < RAM_BYTES) begin
            if (we) begin
                for (int i = 0; i < size; i++) mem_m[a + i] = wd[8*i +: 8];
            end else begin
                lat = 2;
                for (int i = 0; i < size; i++) d = d | (32'(mem_m[a + i]) << (8*i));
                if (sgn && size < 4 && d[8*size-1]) d = d | (32'hFFFF_FFFF << (8*size));
            end
        end else if (a == LED_A || a == SW_A) begin
            if (size != 4) e = 1;
            else if (we) begin
                if (a == LED_A) led_m = wd[15:0];
            end else d = (a == LED_A) ? {16'd0, led_m} : {16'd0, sw_in};
        end else e = 1;
    endfunction

    task automatic do_req(input bit we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] f3, input bit hold,
                          input bit hl, input logic [31:0] ld, input bit le);
        exp_t x;
        int   lat;
        int   n = 0;
        @(negedge clk);
        req_we = we; req_addr = a; req_wdata = wd; req_funct3 = f3; req_valid = 1'b1;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout actual=no_accept expected=accept addr=%h", a);
            req_valid = 1'b0;
            return;
        end
        x.due = cyc + 1;
        @(posedge clk);
        model(we, a, wd, f3, x.d, x.e, lat);
        x.due = x.due + lat - 1;
        x.hl = hl; x.ld = ld; x.le = le;
        q.push_back(x);
        last_due = x.due;
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (!rst) begin
                q.delete();
                last_due = cyc;
                led_m = 16'd0;
                chk("rst_ready", req_ready, 0);
                chk("rst_valid", rsp_valid, 0);
                chk("rst_rdata", rsp_rdata, 0);
                chk("rst_err", rsp_err, 0);
                chk("rst_led", led_out, 0);
            end else begin
                chk("ready", req_ready, cyc > last_due);
                if (q.size() != 0 && q[0].due == cyc) begin
                    chk("rsp_valid", rsp_valid, 1);
                    chk("rsp_rdata", rsp_rdata, q[0].d);
                    chk("rsp_err", rsp_err, q[0].e);
                    if (q[0].hl) begin
                        chk("lit_rdata", rsp_rdata, q[0].ld);
                        chk("lit_err", rsp_err, q[0].le);
                    end
                    void'(q.pop_front());
                end else begin
                    chk("rsp_idle", rsp_valid, 0);
                end
                chk("led", led_out, led_m);
            end
        end
    end

    initial begin
        int n;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h55; req_funct3 = 3'd2;
        repeat (3) @(negedge clk);
        rst = 1'b1; req_valid = 1'b0;

        do_req(1, 32'h10, 32'h8000_00F1, 3'd2, 0, 1, 32'h0, 0);
        do_req(0, 32'h10, 32'h0, 3'd0, 0, 1, 32'hFFFF_FFF1, 0);
        do_req(0, 32'h10, 32'h0, 3'd4, 0, 1, 32'h0000_00F1, 0);
        do_req(0, 32'h10, 32'h0, 3'd2, 0, 1, 32'h8000_00F1, 0);

        do_req(1, 32'h20, 32'h1122_3344, 3'd2, 0, 0, 32'h0, 0);
        do_req(1, 32'h22, 32'h0000_BEEF, 3'd1, 0, 1, 32'h0, 0);
        do_req(0, 32'h20, 32'h0, 3'd2, 0, 1, 32'hBEEF_3344, 0);
        do_req(0, 32'h22, 32'h0, 3'd1, 0, 1, 32'hFFFF_BEEF, 0);
        do_req(1, 32'h21, 32'h0000_005A, 3'd0, 0, 0, 32'h0, 0);
        do_req(0, 32'h20, 32'h0, 3'd2, 0, 1, 32'hBEEF_5A44, 0);

        do_req(0, 32'h13, 32'h0, 3'd2, 0, 1, 32'h0, 1);
        do_req(1, 32'h11, 32'hFFFF, 3'd1, 0, 1, 32'h0, 1);
        do_req(1, 32'h10, 32'h0, 3'd4, 0, 1, 32'h0, 1);
        do_req(0, 32'h10, 32'h0, 3'd3, 0, 1, 32'h0, 1);
        do_req(1, RAM_BYTES, 32'h1234, 3'd2, 0, 1, 32'h0, 1);
        do_req(0, 32'h10, 32'h0, 3'd2, 0, 1, 32'h8000_00F1, 0);

        do_req(1, LED_A, 32'h0001_ABCD, 3'd2, 0, 1, 32'h0, 0);
        do_req(0, LED_A, 32'h0, 3'd2, 0, 1, 32'h0000_ABCD, 0);
        @(negedge clk);
        sw_in = 16'h1234;
        repeat (3) @(negedge clk);
        do_req(0, SW_A, 32'h0, 3'd2, 0, 1, 32'h0000_1234, 0);
        do_req(0, LED_A, 32'h0, 3'd0, 0, 1, 32'h0, 1);
        do_req(1, SW_A, 32'hFFFF_FFFF, 3'd2, 0, 1, 32'h0, 0);

        do_req(0, 32'h20, 32'h0, 3'd2, 1, 1, 32'hBEEF_5A44, 0);
        do_req(0, 32'h23, 32'h0, 3'd4, 1, 1, 32'h0000_00BE, 0);
        do_req(0, 32'h20, 32'h0, 3'd1, 0, 1, 32'h0000_5A44, 0);

        do_req(0, 32'h10, 32'h0, 3'd2, 0, 0, 32'h0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        do_req(0, 32'h10, 32'h0, 3'd2, 0, 1, 32'h8000_00F1, 0);

        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL rsp_drain actual=%0d_pending expected=0_pending", q.size());
        end
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
